instr_mem_loader: RTL and testbench

Controller that owns the write side of the MIPS instruction memory (`ram_instrucciones`). It receives a program as a UART byte stream, packs bytes into 32-bit words, and writes them to consecutive RAM addresses until a HALT word arrives. It then hands the RAM address bus to the CPU fetch stage and enables the CPU. It sits between the UART receiver, the program counter and the instruction RAM, which gains a write port driven only by this block.

---
 rtl/instr_mem_pkg.sv | 29 ++
 rtl/word_packer.sv | 50 +++++
 rtl/instr_mem_loader.sv | 144 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_mem_pkg;

   localparam int unsigned RAM_WIDTH_DEF = 32;
   localparam int unsigned RAM_DEPTH_DEF = 2048;
   localparam logic [31:0] HALT_WORD     = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE,
      S_ERROR
   } loader_state_t;

   // Number of bits needed to hold the value 'depth'.
   function automatic int unsigned clogb2(input int unsigned depth);
      int unsigned bits;
      int unsigned d;
      bits = 0;
      d    = depth;
      while (d > 0) begin
         bits = bits + 1;
         d    = d >> 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/word_packer.sv
// Packs UART bytes MSB-first into a word; flags the word on its last byte.
module word_packer
   import instr_mem_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = RAM_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic [WORD_WIDTH-1:0] word_c,
   output logic                  word_valid_c
);

   localparam int unsigned BYTES = WORD_WIDTH / 8;
   localparam int unsigned IDX_W = (BYTES > 1) ? clogb2(BYTES - 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;

   // Word as it stands once the incoming byte is shifted in.
   assign word_c = (shift_q << 8) | WORD_WIDTH'(in_data);

   always_comb begin
      shift_d      = shift_q;
      idx_d        = idx_q;
      word_valid_c = 1'b0;
      if (clear) begin
         shift_d = '0;
         idx_d   = '0;
      end else if (in_valid) begin
         shift_d      = word_c;
         word_valid_c = (idx_q == LAST_IDX);
         idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a UART byte stream into instruction RAM, then hands the RAM to the CPU.
module instr_mem_loader
   import instr_mem_pkg::*;
#(
   parameter int unsigned          RAM_WIDTH  = RAM_WIDTH_DEF,
   parameter int unsigned          RAM_DEPTH  = RAM_DEPTH_DEF,
   parameter int unsigned          ADDR_WIDTH = clogb2(RAM_DEPTH - 1),
   parameter logic [RAM_WIDTH-1:0] HALT_WORD  = RAM_WIDTH'(instr_mem_pkg::HALT_WORD)
) (
   input  logic                  clka,
   input  logic                  rsta_n,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic [ADDR_WIDTH-1:0] pc_addr,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [RAM_WIDTH-1:0]  ram_din,
   output logic                  ram_we,
   output logic                  cpu_en,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   loader_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
   logic [RAM_WIDTH-1:0]  ram_din_q, ram_din_d;
   logic                  ram_we_q, ram_we_d;
   logic                  cpu_en_q, cpu_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  overflow_q, overflow_d;

   logic                  is_halt_c, at_last_c;
   logic                  pack_clear_c, byte_accept_c;
   logic [RAM_WIDTH-1:0]  word_c;
   logic                  word_valid_c;

   assign is_halt_c    = (ram_din_q == HALT_WORD);
   assign at_last_c    = (wr_ptr_q == LAST_ADDR);
   assign pack_clear_c = start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
   // A byte landing in the WRITE cycle starts the next word only if loading continues.
   assign byte_accept_c = rx_valid &&
                          ((state_q == S_LOAD) ||
                           ((state_q == S_WRITE) && !is_halt_c && !at_last_c));

   word_packer #(
      .WORD_WIDTH (RAM_WIDTH)
   ) u_packer (
      .clk          (clka),
      .rst_n        (rsta_n),
      .clear        (pack_clear_c),
      .in_valid     (byte_accept_c),
      .in_data      (rx_data),
      .word_c       (word_c),
      .word_valid_c (word_valid_c)
   );

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      word_count_d = word_count_q;
      ram_din_d    = ram_din_q;
      ram_we_d     = 1'b0;
      cpu_en_d     = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      overflow_d   = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d      = S_LOAD;
               wr_ptr_d     = '0;
               word_count_d = '0;
            end
         end
         S_LOAD: begin
            if (word_valid_c) begin
               state_d   = S_WRITE;
               ram_din_d = word_c;
            end
         end
         S_WRITE: begin
            word_count_d = word_count_q + 1'b1;
            if (is_halt_c) begin
               state_d = S_DONE;
            end else if (at_last_c) begin
               state_d = S_ERROR;
            end else begin
               state_d  = S_LOAD;
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Status outputs are registered copies of the state being entered.
      ram_we_d   = (state_d == S_WRITE);
      busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
      done_d     = (state_d == S_DONE);
      cpu_en_d   = (state_d == S_DONE);
      overflow_d = (state_d == S_ERROR);
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         word_count_q <= '0;
         ram_din_q    <= '0;
         ram_we_q     <= 1'b0;
         cpu_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         word_count_q <= word_count_d;
         ram_din_q    <= ram_din_d;
         ram_we_q     <= ram_we_d;
         cpu_en_q     <= cpu_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
      end
   end

   // The CPU fetch address drives the RAM once the program is loaded.
   assign ram_addr   = done_q ? pc_addr : wr_ptr_q;
   assign ram_din    = ram_din_q;
   assign ram_we     = ram_we_q;
   assign cpu_en     = cpu_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench: default-depth loader plus a 4-word loader for overflow.
module tb_instr_mem_loader;

   typedef struct packed {
      logic [10:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk;
   logic rst_n;

   logic        start_a, rx_valid_a;
   logic [7:0]  rx_data_a;
   logic [10:0] pc_addr_a, ram_addr_a;
   logic [31:0] ram_din_a;
   logic        ram_we_a, cpu_en_a, busy_a, done_a, overflow_a;
   logic [11:0] word_count_a;

   logic        start_b, rx_valid_b;
   logic [7:0]  rx_data_b;
   logic [1:0]  pc_addr_b, ram_addr_b;
   logic [31:0] ram_din_b;
   logic        ram_we_b, cpu_en_b, busy_b, done_b, overflow_b;
   logic [2:0]  word_count_b;

   wr_t exp_a[$];
   wr_t exp_b[$];
   wr_t got_a, got_b;

   int checks = 0;
   int errors = 0;

   instr_mem_loader dut_a (
      .clka (clk), .rsta_n (rst_n), .start (start_a), .rx_data (rx_data_a),
      .rx_valid (rx_valid_a), .pc_addr (pc_addr_a), .ram_addr (ram_addr_a),
      .ram_din (ram_din_a), .ram_we (ram_we_a), .cpu_en (cpu_en_a), .busy (busy_a),
      .done (done_a), .overflow (overflow_a), .word_count (word_count_a)
   );

   instr_mem_loader #(.RAM_DEPTH(4)) dut_b (
      .clka (clk), .rsta_n (rst_n), .start (start_b), .rx_data (rx_data_b),
      .rx_valid (rx_valid_b), .pc_addr (pc_addr_b), .ram_addr (ram_addr_b),
      .ram_din (ram_din_b), .ram_we (ram_we_b), .cpu_en (cpu_en_b), .busy (busy_b),
      .done (done_b), .overflow (overflow_b), .word_count (word_count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic wr_t mk(input logic [10:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every RAM write must match the head of that DUT's expected queue.
   always @(negedge clk) begin
      if (rst_n && ram_we_a) begin
         checks++;
         if (exp_a.size() == 0) begin
            errors++;
            $display("FAIL wr_a: unexpected write addr %0h data %h", ram_addr_a, ram_din_a);
         end else begin
            got_a = exp_a.pop_front();
            if (got_a.addr !== ram_addr_a || got_a.data !== ram_din_a) begin
               errors++;
               $display("FAIL wr_a: got addr %0h data %h expected addr %0h data %h",
                        ram_addr_a, ram_din_a, got_a.addr, got_a.data);
            end
         end
      end
      if (rst_n && ram_we_b) begin
         checks++;
         if (exp_b.size() == 0) begin
            errors++;
            $display("FAIL wr_b: unexpected write addr %0h data %h", ram_addr_b, ram_din_b);
         end else begin
            got_b = exp_b.pop_front();
            if (got_b.addr !== 11'(ram_addr_b) || got_b.data !== ram_din_b) begin
               errors++;
               $display("FAIL wr_b: got addr %0h data %h expected addr %0h data %h",
                        ram_addr_b, ram_din_b, got_b.addr, got_b.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit sel, input logic [7:0] b);
      if (!sel) begin
         rx_valid_a = 1'b1;
         rx_data_a  = b;
      end else begin
         rx_valid_b = 1'b1;
         rx_data_b  = b;
      end
      tick();
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
   endtask

   task automatic send_word(input bit sel, input logic [31:0] w);
      for (int i = 0; i < 4; i++) send(sel, w[31-8*i -: 8]);
   endtask

   task automatic pulse_start(input bit sel);
      if (!sel) start_a = 1'b1;
      else      start_b = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, "_ram_we"},   32'(ram_we_a), 32'd0);
      check({tag, "_cpu_en"},   32'(cpu_en_a), 32'd0);
      check({tag, "_busy"},     32'(busy_a), 32'd0);
      check({tag, "_done"},     32'(done_a), 32'd0);
      check({tag, "_overflow"}, 32'(overflow_a), 32'd0);
      check({tag, "_ram_din"},  ram_din_a, 32'd0);
      check({tag, "_ram_addr"}, 32'(ram_addr_a), 32'd0);
      check({tag, "_wcount"},   32'(word_count_a), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; rx_valid_a = 1'b0; rx_data_a = 8'h00; pc_addr_a = 11'd0;
      start_b = 1'b0; rx_valid_b = 1'b0; rx_data_b = 8'h00; pc_addr_b = 2'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_a("rst");
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_a("post_rst");

      // Reset in the middle of a partially received word
      pulse_start(1'b0);
      @(negedge clk);
      check("load_busy", 32'(busy_a), 32'd1);
      send(1'b0, 8'hAA);
      send(1'b0, 8'hBB);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle_a("mid_rst");
      tick();
      rst_n = 1'b1;

      exp_a.push_back(mk(11'd0, 32'h1234_5678));
      pulse_start(1'b0);
      send_word(1'b0, 32'h1234_5678);
      repeat (2) tick();
      @(negedge clk);
      check("w0_wcount", 32'(word_count_a), 32'd1);
      check("w0_busy",   32'(busy_a), 32'd1);
      check("w0_ptr",    32'(ram_addr_a), 32'd1);

      // start mid-word is ignored
      exp_a.push_back(mk(11'd1, 32'h9ABC_DEF0));
      send(1'b0, 8'h9A);
      send(1'b0, 8'hBC);
      pulse_start(1'b0);
      send(1'b0, 8'hDE);
      send(1'b0, 8'hF0);
      exp_a.push_back(mk(11'd2, 32'hFFFF_FFFF));
      send_word(1'b0, 32'hFFFF_FFFF);
      @(negedge clk);
      check("h1_we",   32'(ram_we_a), 32'd1);
      check("h1_done", 32'(done_a), 32'd0);
      @(negedge clk);
      check("h1_done_rise", 32'(done_a), 32'd1);
      check("h1_wcount",    32'(word_count_a), 32'd3);

      // Restart from DONE, then a back-to-back two-word program
      pulse_start(1'b0);
      @(negedge clk);
      check("rs_done",   32'(done_a), 32'd0);
      check("rs_cpu_en", 32'(cpu_en_a), 32'd0);
      check("rs_wcount", 32'(word_count_a), 32'd0);
      check("rs_addr",   32'(ram_addr_a), 32'd0);
      exp_a.push_back(mk(11'd0, 32'h2008_0005));
      exp_a.push_back(mk(11'd1, 32'hFFFF_FFFF));
      send_word(1'b0, 32'h2008_0005);
      send_word(1'b0, 32'hFFFF_FFFF);
      @(negedge clk);
      check("p_halt_we",   32'(ram_we_a), 32'd1);
      check("p_done_pre",  32'(done_a), 32'd0);
      @(negedge clk);
      check("p_done",   32'(done_a), 32'd1);
      check("p_cpu_en", 32'(cpu_en_a), 32'd1);
      check("p_busy",   32'(busy_a), 32'd0);
      check("p_wcount", 32'(word_count_a), 32'd2);

      pc_addr_a = 11'd1;
      @(negedge clk);
      check("pc_mux_1", 32'(ram_addr_a), 32'd1);
      pc_addr_a = 11'h7FF;
      @(negedge clk);
      check("pc_mux_7ff", 32'(ram_addr_a), 32'h7FF);
      for (int i = 0; i < 6; i++) begin
         send(1'b0, 8'(8'h11 * (i + 1)));
         @(negedge clk);
         check("done_no_we", 32'(ram_we_a), 32'd0);
      end
      check("done_hold",   32'(done_a), 32'd1);
      check("done_wcount", 32'(word_count_a), 32'd2);

      // Four-word RAM filled without HALT
      pulse_start(1'b1);
      exp_b.push_back(mk(11'd0, 32'h0102_0304));
      exp_b.push_back(mk(11'd1, 32'h0506_0708));
      exp_b.push_back(mk(11'd2, 32'h090A_0B0C));
      exp_b.push_back(mk(11'd3, 32'h0D0E_0F10));
      send_word(1'b1, 32'h0102_0304);
      send_word(1'b1, 32'h0506_0708);
      send_word(1'b1, 32'h090A_0B0C);
      send_word(1'b1, 32'h0D0E_0F10);
      @(negedge clk);
      check("ov_last_we", 32'(ram_we_b), 32'd1);
      @(negedge clk);
      check("ov_flag",   32'(overflow_b), 32'd1);
      check("ov_cpu_en", 32'(cpu_en_b), 32'd0);
      check("ov_done",   32'(done_b), 32'd0);
      check("ov_busy",   32'(busy_b), 32'd0);
      check("ov_wcount", 32'(word_count_b), 32'd4);
      check("ov_addr",   32'(ram_addr_b), 32'd3);
      send_word(1'b1, 32'h5555_5555);
      @(negedge clk);
      check("ov_sticky", 32'(overflow_b), 32'd1);
      pulse_start(1'b1);
      @(negedge clk);
      check("ov_clear",  32'(overflow_b), 32'd0);
      check("ov_rs_wc",  32'(word_count_b), 32'd0);
      check("ov_rs_bsy", 32'(busy_b), 32'd1);

      repeat (3) tick();
      check("exp_a_drained", 32'(exp_a.size()), 32'd0);
      check("exp_b_drained", 32'(exp_b.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
